csr_access_unit: RTL and testbench
==================================

// Module: csr_access_unit
// PURPOSE
//  Execute/writeback-side initiator for the CSR register file. Decodes Zicsr ops (CSRRW/S/C and immediate forms),
//  drives the combinational read address, computes new CSR value, checks privilege/read-only access, and issues
//  registered CSR write-back plus rd write-back one cycle later. Owns the E->W pipeline for CSR ops and the RAW interlock.
// PARAMETERS
//  XLEN        32  data width (only 32 supported)
//  CHECK_PRIV  1   1: enforce csr_addr[9:8] privilege and read-only check; 0: never flag illegal
// PORTS
//  clk              in   1     clock
//  rst              in   1     synchronous reset, active-high
//  stall            in   1     pipeline stall; holds E input and W registers
//  flush            in   1     kill op in E (trap/redirect); W op already issued is not killed
//  csr_valid_i      in   1     CSR instruction present in E
//  funct3_i         in   3     001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI; 000/100 never valid
//  csr_addr_i       in   12    target CSR address
//  rs1_idx_i        in   5     rs1 index (zimm for immediate forms)
//  rs1_data_i       in   32    rs1 operand
//  rd_idx_i         in   5     destination register
//  current_mode     in   2     mode::mode_t, U=00 S=01 M=11
//  csr_address_r    out  12   read address to register file (combinational from E)
//  csr_data         in   32    read data from register file (same cycle)
//  csr_we           out  1     write strobe (W stage)
//  csr_address_wb   out  12   write address (W stage)
//  csr_wb           out  32   write data (W stage)
//  rd_we_o          out  1     GPR write enable (W stage)
//  rd_idx_o         out  5     GPR index (W stage)
//  rd_data_o        out  32    old CSR value (W stage)
//  illegal_o        out  1     illegal-instruction pulse (W stage) to trap logic
//  hazard_o         out  1     E must hold: RAW on CSR address pending in W
// BEHAVIOUR
//  - Reset: all W registers 0; csr_we, rd_we_o, illegal_o, hazard_o = 0; csr_address_wb/csr_wb/rd_* = 0.
//  - csr_address_r = csr_addr_i, unconditional; old = csr_data.
//  - Operand: src = funct3_i[2] ? {27'b0, rs1_idx_i} : rs1_data_i.
//  - New value: RW new=src; RS new=old|src; RC new=old&~src. Full 32-bit, no masking (register file applies WARL).
//  - Write intent: RW/RWI always; RS/RC/RSI/RCI only if rs1_idx_i != 0 (x0/zimm=0 => pure read, csr_we stays 0).
//  - Read intent: rd_we_o = (rd_idx_i != 0) & !illegal.
//  - Illegal (CHECK_PRIV=1): csr_addr_i[9:8] > current_mode, OR csr_addr_i[11:10]==2'b11 with write intent,
//    OR funct3 in {000,100}. Illegal op: csr_we=0, rd_we_o=0, illegal_o=1 for exactly one W cycle.
//  - Capture: E->W on posedge when csr_valid_i & !stall & !flush & !hazard_o; else W valid clears (bubble) unless stall.
//  - Latency: 1 cycle; op in E at cycle n drives csr_we/rd_we_o/illegal_o in cycle n+1; register file commits at end of n+1.
//  - Hazard: hazard_o = csr_valid_i & W_valid & W_write & (W_addr == csr_addr_i). Held E op reissues next cycle,
//    sees updated csr_data. Hazard inserts exactly one bubble.
//  - Stall: W registers hold; csr_we, rd_we_o, illegal_o gated by !stall (no duplicate write/pulse); emitted once
//    in the first cycle stall is low.
//  - Flush with csr_valid_i: E op discarded, W bubble next cycle. Flush and stall together: flush wins for E, W holds.
//  - Back-to-back ops to different addresses: one per cycle, no bubbles.
//  - Reset mid-op: W op dropped, no write issued in cycle after reset.
// TESTING
//  1 M-mode CSRRW 0x340, rs1=0xDEADBEEF, old=0x12, rd=x5 -> next cycle csr_we=1 wb=0xDEADBEEF, rd_data=0x12 to x5.
//  2 CSRRS 0x300 rs1=x0, rd=x3, old=0x88 -> csr_we=0, rd_we=1 data=0x88; CSRRCI zimm=8 old=0x88 -> wb=0x80.
//  3 U-mode CSRRS 0x300 -> illegal_o=1 one cycle, csr_we=0, rd_we=0; M-mode CSRRW 0xF14 -> illegal_o=1; CSRRS 0xF14 rs1=x0 -> legal read.
//  4 CSRRW 0x340=5 then CSRRS 0x340 rd=x6 next cycle -> hazard_o=1 one cycle, second op reads 5, writes nothing extra.
//  5 stall high 3 cycles while W holds write -> csr_we=0 during stall, single csr_we pulse after release.
//  6 rst asserted during W op -> all outputs 0 next cycle, no write; flush with valid op -> no W activity.

Source files
------------

// File: rtl/csr_access_unit.sv
// CSR access unit: decodes Zicsr ops in E, reads the CSR file combinationally, and
// issues the CSR write-back, the rd write-back and the illegal-instruction pulse from a single W register stage.
module csr_access_unit #(
  parameter int XLEN       = 32,
  parameter bit CHECK_PRIV = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            csr_valid_i,
  input  logic [2:0]      funct3_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [4:0]      rs1_idx_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [4:0]      rd_idx_i,
  input  logic [1:0]      current_mode,
  output logic [11:0]     csr_address_r,
  input  logic [XLEN-1:0] csr_data,
  output logic            csr_we,
  output logic [11:0]     csr_address_wb,
  output logic [XLEN-1:0] csr_wb,
  output logic            rd_we_o,
  output logic [4:0]      rd_idx_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            illegal_o,
  output logic            hazard_o
);

  // W-stage contents; write/rd_we are already qualified by legality at capture.
  typedef struct packed {
    logic            valid;
    logic            write;
    logic            rd_we;
    logic            illegal;
    logic [11:0]     addr;
    logic [XLEN-1:0] wdata;
    logic [4:0]      rd_idx;
    logic [XLEN-1:0] rd_data;
  } w_stage_t;

  w_stage_t w_q;

  logic            op_rw;
  logic            op_rs;
  logic            op_rc;
  logic            funct_ok;
  logic [XLEN-1:0] src;
  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] new_val;
  logic            write_intent;
  logic            priv_fault;
  logic            ro_fault;
  logic            illegal;
  logic            capture;

  assign csr_address_r = csr_addr_i;
  assign old_val       = csr_data;

  always_comb begin
    op_rw    = (funct3_i[1:0] == 2'b01);
    op_rs    = (funct3_i[1:0] == 2'b10);
    op_rc    = (funct3_i[1:0] == 2'b11);
    funct_ok = (funct3_i[1:0] != 2'b00);
    src      = funct3_i[2] ? {{(XLEN-5){1'b0}}, rs1_idx_i} : rs1_data_i;

    new_val = old_val;
    if (op_rw)      new_val = src;
    else if (op_rs) new_val = old_val | src;
    else if (op_rc) new_val = old_val & ~src;

    // Set/clear with x0 or zimm=0 is a pure read and must not touch the CSR.
    write_intent = op_rw | ((op_rs | op_rc) & (rs1_idx_i != 5'd0));

    priv_fault = (csr_addr_i[9:8] > current_mode);
    ro_fault   = (csr_addr_i[11:10] == 2'b11) & write_intent;
    illegal    = CHECK_PRIV & (priv_fault | ro_fault | ~funct_ok);
  end

  // E op is accepted only when present, not killed and not waiting on a W write to the same CSR.
  assign hazard_o = csr_valid_i & w_q.valid & w_q.write & (w_q.addr == csr_addr_i);
  assign capture  = csr_valid_i & ~flush & ~hazard_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q <= '0;
    end else if (!stall) begin
      w_q.valid <= capture;
      if (capture) begin
        w_q.write   <= write_intent & ~illegal;
        w_q.rd_we   <= (rd_idx_i != 5'd0) & ~illegal;
        w_q.illegal <= illegal;
        w_q.addr    <= csr_addr_i;
        w_q.wdata   <= new_val;
        w_q.rd_idx  <= rd_idx_i;
        w_q.rd_data <= old_val;
      end
    end
  end

  // Strobes are suppressed while stalled so a held W op fires exactly once, on release.
  assign csr_we         = w_q.valid & w_q.write & ~stall;
  assign rd_we_o        = w_q.valid & w_q.rd_we & ~stall;
  assign illegal_o      = w_q.valid & w_q.illegal & ~stall;
  assign csr_address_wb = w_q.addr;
  assign csr_wb         = w_q.wdata;
  assign rd_idx_o       = w_q.rd_idx;
  assign rd_data_o      = w_q.rd_data;

endmodule

// File: tb/tb_csr_access_unit.sv
// Bench for csr_access_unit: a small CSR file model, a table of single ops and
// hand-written hazard/stall/flush/reset sequences checked through an expected queue.
module tb_csr_access_unit;

  logic        clk = 1'b0;
  logic        rst, stall, flush, csr_valid_i;
  logic [2:0]  funct3_i;
  logic [11:0] csr_addr_i;
  logic [4:0]  rs1_idx_i, rd_idx_i;
  logic [31:0] rs1_data_i;
  logic [1:0]  current_mode;
  logic [11:0] csr_address_r, csr_address_wb;
  logic [31:0] csr_data, csr_wb, rd_data_o;
  logic        csr_we, rd_we_o, illegal_o, hazard_o;
  logic [4:0]  rd_idx_o;

  always #5 clk = ~clk;

  csr_access_unit #(.XLEN(32), .CHECK_PRIV(1'b1)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .csr_valid_i(csr_valid_i),
    .funct3_i(funct3_i), .csr_addr_i(csr_addr_i), .rs1_idx_i(rs1_idx_i),
    .rs1_data_i(rs1_data_i), .rd_idx_i(rd_idx_i), .current_mode(current_mode),
    .csr_address_r(csr_address_r), .csr_data(csr_data), .csr_we(csr_we),
    .csr_address_wb(csr_address_wb), .csr_wb(csr_wb), .rd_we_o(rd_we_o),
    .rd_idx_o(rd_idx_o), .rd_data_o(rd_data_o), .illegal_o(illegal_o), .hazard_o(hazard_o)
  );

  // CSR file model: combinational read, commit at the end of the W cycle, plus a preload port.
  logic [31:0] csr_mem [4096];
  logic        pre_we;
  logic [11:0] pre_addr;
  logic [31:0] pre_data;

  always @(posedge clk) begin
    if (csr_we) csr_mem[csr_address_wb] <= csr_wb;
    if (pre_we) csr_mem[pre_addr] <= pre_data;
  end
  assign csr_data = csr_mem[csr_address_r];

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wb;
    logic        rd_we;
    logic [4:0]  rd_idx;
    logic [31:0] rd_data;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [4:0]  idx;
    logic [31:0] data;
    logic [4:0]  rd;
    logic [1:0]  mode;
    logic [31:0] old;
    logic        we;
    logic [31:0] wb;
    logic        rd_we;
    logic [31:0] rd_data;
    logic        ill;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mkv(logic [2:0] f3, logic [11:0] a, logic [4:0] i, logic [31:0] d,
                               logic [4:0] r, logic [1:0] m, logic [31:0] old, logic we,
                               logic [31:0] wb, logic rwe, logic [31:0] rdat, logic ill);
    vec_t v;
    v.f3 = f3; v.addr = a; v.idx = i; v.data = d; v.rd = r; v.mode = m; v.old = old;
    v.we = we; v.wb = wb; v.rd_we = rwe; v.rd_data = rdat; v.ill = ill;
    return v;
  endfunction

  function automatic exp_t mk(logic we, logic [11:0] a, logic [31:0] wb, logic rwe,
                              logic [4:0] ri, logic [31:0] rdat, logic ill);
    exp_t e;
    e.we = we; e.addr = a; e.wb = wb; e.rd_we = rwe; e.rd_idx = ri; e.rd_data = rdat; e.ill = ill;
    return e;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_w(string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got empty scoreboard expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".csr_we"}, 32'(csr_we), 32'(e.we));
      check({tag, ".rd_we"}, 32'(rd_we_o), 32'(e.rd_we));
      check({tag, ".illegal"}, 32'(illegal_o), 32'(e.ill));
      if (e.we) begin
        check({tag, ".wb_addr"}, 32'(csr_address_wb), 32'(e.addr));
        check({tag, ".wb_data"}, csr_wb, e.wb);
      end
      if (e.rd_we) begin
        check({tag, ".rd_idx"}, 32'(rd_idx_o), 32'(e.rd_idx));
        check({tag, ".rd_data"}, rd_data_o, e.rd_data);
      end
    end
  endtask

  task automatic check_quiet(string tag);
    check({tag, ".csr_we"}, 32'(csr_we), 32'd0);
    check({tag, ".rd_we"}, 32'(rd_we_o), 32'd0);
    check({tag, ".illegal"}, 32'(illegal_o), 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    pre_we = 1'b0;
  endtask

  task automatic preload(logic [11:0] a, logic [31:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
  endtask

  task automatic drive_op(logic [2:0] f3, logic [11:0] a, logic [4:0] i, logic [31:0] d,
                          logic [4:0] r, logic [1:0] m);
    csr_valid_i = 1'b1; funct3_i = f3; csr_addr_i = a; rs1_idx_i = i;
    rs1_data_i = d; rd_idx_i = r; current_mode = m;
  endtask

  task automatic idle();
    csr_valid_i = 1'b0; flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; csr_valid_i = 1'b0; funct3_i = 3'b000;
    csr_addr_i = '0; rs1_idx_i = '0; rs1_data_i = '0; rd_idx_i = '0; current_mode = 2'b11;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;

    vecs[0]  = mkv(3'b001, 12'h340, 5'd1, 32'hDEADBEEF, 5'd5,  2'b11, 32'h12,       1, 32'hDEADBEEF, 1, 32'h12, 0);
    vecs[1]  = mkv(3'b010, 12'h300, 5'd0, 32'h0,        5'd3,  2'b11, 32'h88,       0, 32'h0,        1, 32'h88, 0);
    vecs[2]  = mkv(3'b111, 12'h300, 5'd8, 32'h0,        5'd0,  2'b11, 32'h88,       1, 32'h80,       0, 32'h0,  0);
    vecs[3]  = mkv(3'b010, 12'h300, 5'd1, 32'h1,        5'd2,  2'b00, 32'h0,        0, 32'h0,        0, 32'h0,  1);
    vecs[4]  = mkv(3'b001, 12'hF14, 5'd1, 32'h0,        5'd2,  2'b11, 32'h0,        0, 32'h0,        0, 32'h0,  1);
    vecs[5]  = mkv(3'b010, 12'hF14, 5'd0, 32'h0,        5'd4,  2'b11, 32'hA5,       0, 32'h0,        1, 32'hA5, 0);
    vecs[6]  = mkv(3'b110, 12'h341, 5'd5, 32'h0,        5'd7,  2'b11, 32'hF0,       1, 32'hF5,       1, 32'hF0, 0);
    vecs[7]  = mkv(3'b101, 12'h305, 5'd0, 32'hFFFF,     5'd0,  2'b11, 32'h1234,     1, 32'h0,        0, 32'h0,  0);
    vecs[8]  = mkv(3'b011, 12'h344, 5'd9, 32'h0000FF00, 5'd10, 2'b11, 32'h12345678, 1, 32'h12340078, 1, 32'h12345678, 0);
    vecs[9]  = mkv(3'b000, 12'h340, 5'd1, 32'h5,        5'd1,  2'b11, 32'h0,        0, 32'h0,        0, 32'h0,  1);
    vecs[10] = mkv(3'b100, 12'h340, 5'd1, 32'h5,        5'd1,  2'b11, 32'h0,        0, 32'h0,        0, 32'h0,  1);
    vecs[11] = mkv(3'b001, 12'h300, 5'd1, 32'h7,        5'd1,  2'b01, 32'h0,        0, 32'h0,        0, 32'h0,  1);
    vecs[12] = mkv(3'b010, 12'h100, 5'd0, 32'h0,        5'd1,  2'b01, 32'h22,       0, 32'h0,        1, 32'h22, 0);
    vecs[13] = mkv(3'b001, 12'h001, 5'd2, 32'h1F,       5'd1,  2'b00, 32'h3,        1, 32'h1F,       1, 32'h3,  0);
    vecs[14] = mkv(3'b011, 12'hC00, 5'd0, 32'h0,        5'd11, 2'b00, 32'hABCD,     0, 32'h0,        1, 32'hABCD, 0);
    vecs[15] = mkv(3'b110, 12'hC00, 5'd1, 32'h0,        5'd11, 2'b00, 32'h0,        0, 32'h0,        0, 32'h0,  1);

    // Reset state
    tick(); tick();
    @(negedge clk);
    check_quiet("reset");
    check("reset.hazard", 32'(hazard_o), 32'd0);
    check("reset.wb_addr", 32'(csr_address_wb), 32'd0);
    check("reset.wb_data", csr_wb, 32'd0);
    check("reset.rd_idx", 32'(rd_idx_o), 32'd0);
    check("reset.rd_data", rd_data_o, 32'd0);
    tick();
    rst = 1'b0;

    // Table of isolated single ops
    for (int k = 0; k < 16; k++) begin
      tick();
      idle();
      preload(vecs[k].addr, vecs[k].old);
      tick();
      drive_op(vecs[k].f3, vecs[k].addr, vecs[k].idx, vecs[k].data, vecs[k].rd, vecs[k].mode);
      exp_q.push_back(mk(vecs[k].we, vecs[k].addr, vecs[k].wb, vecs[k].rd_we, vecs[k].rd,
                         vecs[k].rd_data, vecs[k].ill));
      @(negedge clk);
      check($sformatf("vec%0d.rd_addr", k), 32'(csr_address_r), 32'(vecs[k].addr));
      check($sformatf("vec%0d.hazard", k), 32'(hazard_o), 32'd0);
      tick();
      idle();
      @(negedge clk);
      check_w($sformatf("vec%0d", k));
    end

    // Illegal pulse lasts a single cycle
    tick();
    drive_op(3'b010, 12'h300, 5'd1, 32'h1, 5'd2, 2'b00);
    exp_q.push_back(mk(0, 12'h0, 32'h0, 0, 5'd0, 32'h0, 1));
    tick();
    idle();
    @(negedge clk);
    check_w("ill_pulse");
    tick();
    @(negedge clk);
    check_quiet("ill_after");

    // Back-to-back ops to different CSRs
    tick(); preload(12'h341, 32'hA);
    tick(); preload(12'h342, 32'hB);
    tick();
    drive_op(3'b001, 12'h341, 5'd1, 32'h1, 5'd1, 2'b11);
    exp_q.push_back(mk(1, 12'h341, 32'h1, 1, 5'd1, 32'hA, 0));
    tick();
    drive_op(3'b010, 12'h342, 5'd3, 32'h10, 5'd2, 2'b11);
    exp_q.push_back(mk(1, 12'h342, 32'h1B, 1, 5'd2, 32'hB, 0));
    @(negedge clk);
    check("b2b.hazard", 32'(hazard_o), 32'd0);
    check_w("b2b0");
    tick();
    idle();
    @(negedge clk);
    check_w("b2b1");

    // RAW hazard: write 0x340 then read it back immediately
    tick(); preload(12'h340, 32'h0);
    tick();
    drive_op(3'b001, 12'h340, 5'd1, 32'h5, 5'd0, 2'b11);
    exp_q.push_back(mk(1, 12'h340, 32'h5, 0, 5'd0, 32'h0, 0));
    tick();
    drive_op(3'b010, 12'h340, 5'd0, 32'h0, 5'd6, 2'b11);
    exp_q.push_back(mk(0, 12'h0, 32'h0, 0, 5'd0, 32'h0, 0));
    @(negedge clk);
    check("raw.hazard_on", 32'(hazard_o), 32'd1);
    check_w("raw.write");
    tick();
    exp_q.push_back(mk(0, 12'h0, 32'h0, 1, 5'd6, 32'h5, 0));
    @(negedge clk);
    check("raw.hazard_off", 32'(hazard_o), 32'd0);
    check_w("raw.bubble");
    tick();
    idle();
    @(negedge clk);
    check_w("raw.read");

    // Stall holds W for 3 cycles; a flushed op during stall must never appear
    tick(); preload(12'h343, 32'h9);
    tick();
    drive_op(3'b001, 12'h343, 5'd1, 32'h77, 5'd8, 2'b11);
    exp_q.push_back(mk(1, 12'h343, 32'h77, 1, 5'd8, 32'h9, 0));
    tick();
    idle(); stall = 1'b1;
    @(negedge clk);
    check_quiet("stall0");
    tick();
    drive_op(3'b001, 12'h344, 5'd1, 32'h33, 5'd9, 2'b11); flush = 1'b1;
    @(negedge clk);
    check_quiet("stall1");
    tick();
    idle();
    @(negedge clk);
    check_quiet("stall2");
    tick();
    stall = 1'b0;
    @(negedge clk);
    check_w("stall.release");
    tick();
    @(negedge clk);
    check_quiet("stall.after");
    check("stall.commit", csr_mem[12'h343], 32'h77);

    // Flush with a valid op leaves no W activity
    tick();
    drive_op(3'b001, 12'h345, 5'd1, 32'h44, 5'd4, 2'b11); flush = 1'b1;
    tick();
    idle();
    @(negedge clk);
    check_quiet("flush");

    // Reset on the capture edge drops the op
    tick(); preload(12'h346, 32'h1);
    tick();
    drive_op(3'b001, 12'h346, 5'd1, 32'h55, 5'd9, 2'b11); rst = 1'b1;
    tick();
    idle(); rst = 1'b0;
    @(negedge clk);
    check_quiet("rst_e");
    tick();
    check("rst_e.mem", csr_mem[12'h346], 32'h1);

    // Reset while W holds a stalled op drops it
    tick(); preload(12'h347, 32'h2);
    tick();
    drive_op(3'b001, 12'h347, 5'd1, 32'h66, 5'd9, 2'b11);
    tick();
    idle(); stall = 1'b1; rst = 1'b1;
    @(negedge clk);
    check_quiet("rst_w.stalled");
    tick();
    stall = 1'b0; rst = 1'b0;
    @(negedge clk);
    check_quiet("rst_w");
    tick();
    check("rst_w.mem", csr_mem[12'h347], 32'h2);

    check("scoreboard.left", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
